rot_entry_alu: RTL and testbench

Parametrised rotary-shaft operand entry and add/subtract unit for the lab board. Each detent of the rotary shaft latches one switch chunk into operand A, then B, then computes a signed result with overflow. It replaces the fixed 7-bit, 4-step entry adder. Added over that version: a synchronised, clock-domain step detector (no derived clocks), generic width, four arithmetic modes, a result-valid strobe and an abort input.

---
 rtl/rot_pkg.sv | 21 ++
 rtl/rot_step_detect.sv | 42 ++++
 rtl/rot_entry_alu.sv | 138 +++++++++++++
 tb/tb_rot_entry_alu.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/rot_pkg.sv
// Shared definitions for the rotary-shaft operand entry blocks: arithmetic
// mode codes, FSM phase encodings and the chunk-count helper.
package rot_pkg;

    localparam logic [1:0] MODE_ADD  = 2'b00;
    localparam logic [1:0] MODE_SUB  = 2'b01;
    localparam logic [1:0] MODE_SADD = 2'b10;
    localparam logic [1:0] MODE_SSUB = 2'b11;

    typedef enum logic [1:0] {
        PH_LOAD_A = 2'd0,
        PH_LOAD_B = 2'd1,
        PH_CALC   = 2'd2
    } phase_e;

    // Number of switch chunks needed to fill a width-bit operand.
    function automatic int chunks(input int width, input int din_w);
        return (width + din_w - 1) / din_w;
    endfunction

endpackage

// File: rtl/rot_step_detect.sv
// Rotary detent detector: synchronises both raw contacts, tracks a
// set-on-both-high / clear-on-both-low event flag and emits a one-cycle step.
module rot_step_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic i_rota,
    input  logic i_rotb,
    output logic o_step
);

    logic r_a_meta, r_a_sync;
    logic r_b_meta, r_b_sync;
    logic r_event, r_event_d;

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the
    // synchroniser chain into a single stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_meta  <= 1'b0;
            r_a_sync  <= 1'b0;
            r_b_meta  <= 1'b0;
            r_b_sync  <= 1'b0;
            r_event   <= 1'b0;
            r_event_d <= 1'b0;
        end else begin
            r_a_meta  <= i_rota;
            r_a_sync  <= r_a_meta;
            r_b_meta  <= i_rotb;
            r_b_sync  <= r_b_meta;
            // Hysteresis: only a full return to both-low re-arms the detector.
            if (r_a_sync && r_b_sync)
                r_event <= 1'b1;
            else if (!r_a_sync && !r_b_sync)
                r_event <= 1'b0;
            r_event_d <= r_event;
        end
    end

    assign o_step = r_event & ~r_event_d;

endmodule

// File: rtl/rot_entry_alu.sv
// Rotary-shaft operand entry and add/subtract unit: each detent loads one
// switch chunk into A then B, after which a signed result is registered.
module rot_entry_alu
    import rot_pkg::*;
#(
    parameter  int WIDTH = 7,
    parameter  int DIN_W = 4,
    localparam int IDX_W = (chunks(WIDTH, DIN_W) > 1) ? $clog2(chunks(WIDTH, DIN_W)) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rota,
    input  logic             rotb,
    input  logic [DIN_W-1:0] din,
    input  logic [1:0]       mode,
    input  logic             clr,
    output logic [WIDTH-1:0] sum,
    output logic             ovf,
    output logic             cout,
    output logic             valid,
    output logic [1:0]       phase,
    output logic [IDX_W-1:0] chunk_idx
);

    localparam int               CHUNKS   = chunks(WIDTH, DIN_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

    logic [WIDTH-1:0] r_a, r_b, r_sum;
    logic [1:0]       r_mode;
    phase_e           r_phase;
    logic [IDX_W-1:0] r_idx;
    logic             r_ovf, r_cout, r_valid;

    logic             w_step;
    logic [5:0]       w_shift;
    logic [WIDTH-1:0] w_mask, w_chunk, w_target, w_merged;
    logic             w_sub, w_sat;
    logic [WIDTH-1:0] w_b_eff, w_res;
    logic [WIDTH:0]   w_full;
    logic             w_carry_msb, w_ovf, w_cout;

    rot_step_detect u_step (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_rota (rota),
        .i_rotb (rotb),
        .o_step (w_step)
    );

    // Splice din into the selected operand; the mask drops any din bits
    // that fall above WIDTH on the last chunk.
    assign w_shift  = 6'(r_idx) * 6'(DIN_W);
    assign w_mask   = WIDTH'({DIN_W{1'b1}}) << w_shift;
    assign w_chunk  = WIDTH'(din) << w_shift;
    assign w_target = (r_phase == PH_LOAD_A) ? r_a : r_b;
    assign w_merged = (w_target & ~w_mask) | (w_chunk & w_mask);

    // NOTE: every variable written in always_comb is given a value on every
    // path (here the unsaturated result first); a missed path infers a latch.
    always_comb begin
        w_sub       = (r_mode == MODE_SUB)  || (r_mode == MODE_SSUB);
        w_sat       = (r_mode == MODE_SADD) || (r_mode == MODE_SSUB);
        w_b_eff     = r_b ^ {WIDTH{w_sub}};
        w_full      = {1'b0, r_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_sub};
        // The MSB sum bit is a ^ b ^ carry_in, so the carry into it falls out.
        w_carry_msb = w_full[WIDTH-1] ^ r_a[WIDTH-1] ^ w_b_eff[WIDTH-1];
        w_ovf       = w_carry_msb ^ w_full[WIDTH];
        w_cout      = w_full[WIDTH] ^ w_sub;
        w_res       = w_full[WIDTH-1:0];
        if (w_sat && w_ovf)
            w_res = r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_mode  <= MODE_ADD;
            r_phase <= PH_LOAD_A;
            r_idx   <= '0;
            r_sum   <= '0;
            r_ovf   <= 1'b0;
            r_cout  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (clr) begin
                // Abort wins over a coincident step; the last result is kept.
                r_phase <= PH_LOAD_A;
                r_idx   <= '0;
                r_a     <= '0;
                r_b     <= '0;
            end else begin
                case (r_phase)
                    PH_LOAD_A: begin
                        if (w_step) begin
                            r_a <= w_merged;
                            if (r_idx == LAST_IDX) begin
                                r_idx   <= '0;
                                r_phase <= PH_LOAD_B;
                            end else begin
                                r_idx <= r_idx + IDX_W'(1);
                            end
                        end
                    end
                    PH_LOAD_B: begin
                        if (w_step) begin
                            r_b <= w_merged;
                            if (r_idx == LAST_IDX) begin
                                r_idx   <= '0;
                                r_mode  <= mode;
                                r_phase <= PH_CALC;
                            end else begin
                                r_idx <= r_idx + IDX_W'(1);
                            end
                        end
                    end
                    PH_CALC: begin
                        r_sum   <= w_res;
                        r_ovf   <= w_ovf;
                        r_cout  <= w_cout;
                        r_valid <= 1'b1;
                        r_phase <= PH_LOAD_A;
                    end
                    default: r_phase <= PH_LOAD_A;
                endcase
            end
        end
    end

    assign sum       = r_sum;
    assign ovf       = r_ovf;
    assign cout      = r_cout;
    assign valid     = r_valid;
    assign phase     = r_phase;
    assign chunk_idx = r_idx;

endmodule

// File: tb/tb_rot_entry_alu.sv
// Self-checking bench: drives a 7-bit and an 8-bit instance from the same
// rotary/switch stimulus and compares both against an integer reference model.
module tb_rot_entry_alu;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rota = 1'b0, rotb = 1'b0, clr = 1'b0;
    logic [3:0] din = 4'h0;
    logic [1:0] mode = 2'b00;

    logic [6:0] sum7;
    logic       ovf7, cout7, valid7;
    logic [1:0] phase7;
    logic [0:0] chunk7;
    logic [7:0] sum8;
    logic       ovf8, cout8, valid8;
    logic [1:0] phase8;
    logic [0:0] chunk8;

    int total = 0, bad = 0;
    int vcnt7 = 0, vcnt8 = 0, ops = 0, cnt = 0;
    logic [31:0] exp_s7 = 0, exp_s8 = 0;
    logic        exp_o7 = 0, exp_c7 = 0, exp_o8 = 0, exp_c8 = 0;

    rot_entry_alu #(.WIDTH(7), .DIN_W(4)) dut7 (
        .clk(clk), .rst_n(rst_n), .rota(rota), .rotb(rotb), .din(din),
        .mode(mode), .clr(clr), .sum(sum7), .ovf(ovf7), .cout(cout7),
        .valid(valid7), .phase(phase7), .chunk_idx(chunk7)
    );

    rot_entry_alu #(.WIDTH(8), .DIN_W(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .rota(rota), .rotb(rotb), .din(din),
        .mode(mode), .clr(clr), .sum(sum8), .ovf(ovf8), .cout(cout8),
        .valid(valid8), .phase(phase8), .chunk_idx(chunk8)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid7) vcnt7 <= vcnt7 + 1;
        if (valid8) vcnt8 <= vcnt8 + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Integer model: signed overflow is judged on the true mathematical result.
    function automatic void ref_alu(input int w, input longint a_in, input longint b_in,
                                    input logic [1:0] md, output logic [31:0] s,
                                    output logic o, output logic c);
        longint full, half, a, b, sa, sb, t, u;
        full = longint'(1) << w;
        half = full / 2;
        a  = a_in & (full - 1);
        b  = b_in & (full - 1);
        sa = (a >= half) ? a - full : a;
        sb = (b >= half) ? b - full : b;
        if (md[0]) begin
            t = sa - sb; u = a - b; c = (a < b);
        end else begin
            t = sa + sb; u = a + b; c = (u >= full);
        end
        o = (t >= half) || (t < -half);
        u = u & (full - 1);
        if (md[1] && o) u = (sa >= 0) ? half - 1 : half;
        s = 32'(u);
    endfunction

    // One detent: both contacts high for 6 cycles (optionally bouncing rotb
    // afterwards), then both low. Samples valid at each negedge while high.
    task automatic step(input int clr_cyc, input bit bounce,
                        output logic [5:0] vp7, output logic [5:0] vp8);
        vp7 = '0; vp8 = '0;
        rota = 1'b1; rotb = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            vp7[i-1] = valid7;
            vp8[i-1] = valid8;
            clr = (i == clr_cyc);
        end
        clr = 1'b0;
        if (bounce) begin
            for (int j = 0; j < 4; j++) begin
                rotb = j[0];
                repeat (3) @(negedge clk);
            end
        end
        rota = 1'b0; rotb = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic check_pos(input string tag);
        check({tag, "_ph7"},  32'(phase7), 32'(cnt / 2));
        check({tag, "_idx7"}, 32'(chunk7), 32'(cnt % 2));
        check({tag, "_ph8"},  32'(phase8), 32'(cnt / 2));
        check({tag, "_idx8"}, 32'(chunk8), 32'(cnt % 2));
    endtask

    task automatic check_result(input string tag);
        check({tag, "_sum7"},  32'(sum7),  exp_s7);
        check({tag, "_ovf7"},  32'(ovf7),  32'(exp_o7));
        check({tag, "_cout7"}, 32'(cout7), 32'(exp_c7));
        check({tag, "_sum8"},  32'(sum8),  exp_s8);
        check({tag, "_ovf8"},  32'(ovf8),  32'(exp_o8));
        check({tag, "_cout8"}, 32'(cout8), 32'(exp_c8));
    endtask

    // Full operation of four chunks; mode wiggles randomly except on the
    // final B chunk, where it must be sampled.
    task automatic run_op(input string tag, input logic [3:0] a0, a1, b0, b1,
                          input logic [1:0] md, input bit bounce);
        logic [5:0] p7, p8;
        din = a0; mode = 2'($urandom);
        step(0, bounce, p7, p8); cnt = 1; check_pos({tag, "_s1"});
        din = a1; mode = 2'($urandom);
        step(0, 1'b0, p7, p8); cnt = 2; check_pos({tag, "_s2"});
        din = b0; mode = 2'($urandom);
        step(0, 1'b0, p7, p8); cnt = 3; check_pos({tag, "_s3"});
        din = b1; mode = md;
        step(0, 1'b0, p7, p8); cnt = 0; check_pos({tag, "_s4"});
        mode = 2'($urandom);
        ref_alu(7, longint'({a1, a0}), longint'({b1, b0}), md, exp_s7, exp_o7, exp_c7);
        ref_alu(8, longint'({a1, a0}), longint'({b1, b0}), md, exp_s8, exp_o8, exp_c8);
        check({tag, "_vpat7"}, 32'(p7), 32'(6'b010000));
        check({tag, "_vpat8"}, 32'(p8), 32'(6'b010000));
        check_result(tag);
        ops++;
    endtask

    task automatic run_rand(input string tag);
        run_op(tag, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
               2'($urandom), 1'b0);
    endtask

    initial begin
        logic [5:0] p7, p8;

        // Reset with random contact activity: nothing may move.
        for (int i = 0; i < 10; i++) begin
            rota = 1'($urandom); rotb = 1'($urandom);
            @(negedge clk);
            check("rst_sum7", 32'(sum7), 0);
            check("rst_valid7", 32'(valid7), 0);
            check("rst_valid8", 32'(valid8), 0);
            check("rst_ph7", 32'(phase7), 0);
        end
        check("rst_ovf7", 32'(ovf7), 0);
        check("rst_cout7", 32'(cout7), 0);
        check("rst_idx7", 32'(chunk7), 0);
        check("rst_sum8", 32'(sum8), 0);
        rota = 1'b0; rotb = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Directed arithmetic cases.
        run_op("add",   4'h5, 4'h1, 4'hA, 4'h0, 2'b00, 1'b0);
        run_op("subov", 4'hF, 4'h3, 4'h1, 4'h4, 2'b01, 1'b0);
        run_op("ssub",  4'hF, 4'h3, 4'h1, 4'h4, 2'b11, 1'b0);
        run_op("w8add", 4'hF, 4'h7, 4'h1, 4'h0, 2'b00, 1'b0);
        run_op("w8sad", 4'hF, 4'h7, 4'h1, 4'h0, 2'b10, 1'b0);
        run_op("w8ssb", 4'h0, 4'h8, 4'h1, 4'h0, 2'b11, 1'b0);

        // Contact bounce on the first step of an operation.
        run_op("bounce", 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
               2'($urandom), 1'b1);

        // Abort while loading B: position clears, result holds.
        for (int i = 0; i < 3; i++) begin
            din = 4'($urandom);
            step(0, 1'b0, p7, p8);
        end
        cnt = 3; check_pos("clrb_pre");
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        cnt = 0; check_pos("clrb");
        check_result("clrb_hold");
        run_rand("after_clrb");

        // Abort coincident with a step: the step is dropped.
        din = 4'($urandom);
        step(3, 1'b0, p7, p8);
        cnt = 0; check_pos("clrstep");
        run_rand("after_clrstep");

        // Asynchronous reset pulse between clock edges during LOAD_B.
        run_rand("pre_rst");
        for (int i = 0; i < 2; i++) begin
            din = 4'($urandom);
            step(0, 1'b0, p7, p8);
        end
        cnt = 2; check_pos("midrst_pre");
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        cnt = 0;
        exp_s7 = 0; exp_o7 = 0; exp_c7 = 0;
        exp_s8 = 0; exp_o8 = 0; exp_c8 = 0;
        check_pos("midrst");
        check_result("midrst");
        #2 rst_n = 1'b1;
        @(negedge clk);
        run_rand("after_rst");

        // Random operations.
        for (int n = 0; n < 16; n++) run_rand("rand");

        repeat (4) @(negedge clk);
        check("vcnt7", 32'(vcnt7), 32'(ops));
        check("vcnt8", 32'(vcnt8), 32'(ops));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
